// File: rtl/ram_stream_reader_if.sv
// Command and output-stream handshake bundle for ram_stream_reader.
// The slave modport is the reader's view; the master modport is the driver/sink side.
interface ram_stream_reader_if #(
    parameter int width_p = 8,
    parameter int depth_p = 32
);
    logic                       cmd_valid_i;
    logic                       cmd_ready_o;
    logic [$clog2(depth_p)-1:0] cmd_addr_i;
    logic [$clog2(depth_p):0]   cmd_len_i;
    logic                       data_valid_o;
    logic [width_p-1:0]         data_o;
    logic                       data_last_o;
    logic                       data_ready_i;

    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_len_i, data_ready_i,
        output cmd_ready_o, data_valid_o, data_o, data_last_o
    );

    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_len_i, data_ready_i,
        input  cmd_ready_o, data_valid_o, data_o, data_last_o
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams a run of words from an async-read RAM onto a registered ready/valid output.
// Optional running checksum output sum_o is enabled by RAM_STREAM_READER_CHECKSUM_EN.
module ram_stream_reader #(
    parameter int width_p = 8,
    parameter int depth_p = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    ram_stream_reader_if.slave         s_if,
    output logic                       rd_valid_o,
    output logic [$clog2(depth_p)-1:0] rd_addr_o,
    input  logic [width_p-1:0]         rd_data_i,
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    output logic [width_p-1:0]         sum_o,
`endif
    output logic                       busy_o
);
    localparam int AW = $clog2(depth_p);
    localparam int CW = AW + 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [width_p-1:0] data_q, data_d;
    logic               dvld_q, dvld_d;
    logic               last_q, last_d;

    logic               accept, load, xfer;
    logic [CW-1:0]      len_sat;

    assign accept  = (state_q == IDLE) && s_if.cmd_valid_i;
    assign load    = (state_q == STREAM) && (cnt_q != '0) && (!dvld_q || s_if.data_ready_i);
    assign xfer    = dvld_q && s_if.data_ready_i;
    assign len_sat = (s_if.cmd_len_i > CW'(depth_p)) ? CW'(depth_p) : s_if.cmd_len_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        dvld_d  = dvld_q;
        last_d  = last_q;

        if (accept) begin
            ptr_d   = s_if.cmd_addr_i;
            cnt_d   = len_sat;
            state_d = (len_sat != '0) ? STREAM : IDLE;
        end

        if (load) begin
            data_d = rd_data_i;
            dvld_d = 1'b1;
            last_d = (cnt_q == CW'(1));
            // Explicit wrap keeps non-power-of-two depths in range.
            ptr_d  = (ptr_q == AW'(depth_p - 1)) ? '0 : ptr_q + AW'(1);
            cnt_d  = cnt_q - CW'(1);
        end else if (xfer) begin
            dvld_d = 1'b0;
        end

        if (xfer && last_q) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            dvld_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dvld_q  <= dvld_d;
            last_q  <= last_d;
        end
    end

`ifdef RAM_STREAM_READER_CHECKSUM_EN
    logic [width_p-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (accept) begin
            sum_d = '0;
        end else if (xfer) begin
            sum_d = sum_q + data_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;
`endif

    assign s_if.cmd_ready_o  = (state_q == IDLE);
    assign s_if.data_valid_o = dvld_q;
    assign s_if.data_o       = data_q;
    assign s_if.data_last_o  = last_q;
    assign rd_valid_o        = load;
    assign rd_addr_o         = ptr_q;
    assign busy_o            = (state_q == STREAM);
endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: commands push expected words, a negedge monitor pops and compares.
module tb_ram_stream_reader;
    localparam int W     = 8;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          reset_ni;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          busy;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    logic [W-1:0]  sum;
`endif

    logic [W-1:0]  mem [DEPTH];
    logic [W:0]    exp_q [$];
    int            vectors = 0;
    int            errors  = 0;
    int            rdy_mode = 0;

    ram_stream_reader_if #(.width_p(W), .depth_p(DEPTH)) bus ();

    ram_stream_reader #(.width_p(W), .depth_p(DEPTH)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_ni),
        .s_if       (bus.slave),
        .rd_valid_o (rd_valid),
        .rd_addr_o  (rd_addr),
        .rd_data_i  (rd_data),
`ifdef RAM_STREAM_READER_CHECKSUM_EN
        .sum_o      (sum),
`endif
        .busy_o     (busy)
    );

    assign rd_data = mem[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1,..., 2 = random.
    initial begin
        int ph = 0;
        bus.data_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: bus.data_ready_i = 1'b1;
                1: bus.data_ready_i = (ph % 3) == 0;
                default: bus.data_ready_i = $urandom_range(0, 1);
            endcase
            ph++;
        end
    end

    // Monitor: every transfer must match the head of the expected queue.
    initial begin
        logic         stalled = 1'b0;
        logic [W+1:0] held = '0;
        logic [W:0]   e;
        forever begin
            @(negedge clk);
            if (!reset_ni) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    check("stall_hold", int'({bus.data_last_o, bus.data_valid_o, bus.data_o}), int'(held));
                if (bus.data_valid_o && !bus.data_ready_i)
                    check("no_fetch_while_stalled", int'(rd_valid), 0);
                if (bus.data_valid_o && bus.data_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", int'(bus.data_o), int'(e[W-1:0]));
                        check("last", int'(bus.data_last_o), int'(e[W]));
                    end
                end
                stalled = bus.data_valid_o && !bus.data_ready_i;
                held    = {bus.data_last_o, bus.data_valid_o, bus.data_o};
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 one cycle after the accept edge.
    task automatic send_cmd(input int addr, input int len);
        int n;
        int guard = 0;
        while (!bus.cmd_ready_o && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("cmd_ready_timeout", int'(bus.cmd_ready_o), 1);
        n = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, mem[(addr + i) % DEPTH]});
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = AW'(addr);
        bus.cmd_len_i   = (AW + 1)'(len);
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        check("first_fetch_strobe", int'(rd_valid), (n > 0) ? 1 : 0);
        if (n > 0) check("first_fetch_addr", int'(rd_addr), addr);
        check("busy_after_accept", int'(busy), (n > 0) ? 1 : 0);
        @(posedge clk); #1;
        check("first_word_latency", int'(bus.data_valid_o), (n > 0) ? 1 : 0);
        if (n == 0) check("zero_len_ready", int'(bus.cmd_ready_o), 1);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!(exp_q.size() == 0 && bus.cmd_ready_o) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_remaining", exp_q.size(), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_valid", int'(bus.data_valid_o), 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
    endtask

    task automatic check_reset_state();
        check("rst_valid", int'(bus.data_valid_o), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cmd_ready", int'(bus.cmd_ready_o), 1);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_data", int'(bus.data_o), 0);
        check("rst_last", int'(bus.data_last_o), 0);
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_len_i   = '0;
        reset_ni        = 1'b0;
        fill_random();
        repeat (2) @(posedge clk);
        #1 reset_ni = 1'b1;
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #1;

        // Basic stream under continuous ready.
        mem[4] = 8'd11; mem[5] = 8'd22; mem[6] = 8'd33; mem[7] = 8'd44;
        rdy_mode = 0;
        send_cmd(4, 4);
        wait_idle();

        // Same stream with 1,0,0 backpressure.
        rdy_mode = 1;
        send_cmd(4, 4);
        wait_idle();

        // Wrap and saturation.
        rdy_mode = 0;
        send_cmd(30, 3);
        wait_idle();
        rdy_mode = 2;
        send_cmd(30, 40);
        wait_idle();

        // Zero length.
        send_cmd(9, 0);
        wait_idle();

        // Commands during a stream are ignored.
        rdy_mode = 1;
        send_cmd(8, 6);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = AW'(0);
        bus.cmd_len_i   = (AW + 1)'(5);
        repeat (2) begin
            check("stream_cmd_ready", int'(bus.cmd_ready_o), 0);
            check("stream_busy", int'(busy), 1);
            @(posedge clk); #1;
        end
        bus.cmd_valid_i = 1'b0;
        wait_idle();

        // Reset mid-stream discards the pending words.
        rdy_mode = 2;
        send_cmd(2, 10);
        repeat (3) @(posedge clk);
        #1 reset_ni = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_ni = 1'b1;
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #1;

`ifdef RAM_STREAM_READER_CHECKSUM_EN
        rdy_mode = 1;
        mem[12] = 8'hF0; mem[13] = 8'h20; mem[14] = 8'h05;
        send_cmd(12, 3);
        wait_idle();
        check("sum_final", int'(sum), 8'h15);
        repeat (3) @(posedge clk);
        #1;
        check("sum_hold", int'(sum), 8'h15);
        send_cmd(0, 0);
        check("sum_clear", int'(sum), 0);
`endif

        // Randomized commands against the address/length model.
        for (int k = 0; k < 25; k++) begin
            fill_random();
            rdy_mode = $urandom_range(0, 2);
            send_cmd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH + 8));
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
